// File: rtl/seq_multiplier_pkg.sv
// rtl/seq_multiplier_pkg.sv - shared FSM encoding and counter sizing for seq_multiplier
package seq_multiplier_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter must hold the value WIDTH itself, not just WIDTH-1.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_multiplier_mul_step.sv
// rtl/seq_multiplier_mul_step.sv - one combinational shift-and-add iteration
module mul_step #(
  parameter int WIDTH = 4
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [2*WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0]   mplier_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [2*WIDTH-1:0] mcand_o,
  output logic [WIDTH-1:0]   mplier_o,
  output logic               mplier_zero_o
);

  // The product fits in 2*WIDTH bits, so the add can never carry out.
  assign acc_o         = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
  assign mcand_o       = mcand_i << 1;
  assign mplier_o      = mplier_i >> 1;
  assign mplier_zero_o = (mplier_o == '0);

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - sequential shift-and-add unsigned multiplier, start/done handshake
// Optional early completion when the remaining multiplier is zero: SEQ_MULTIPLIER_EARLY_DONE_EN
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out,
  output logic               overflow
);

  localparam int CW = cnt_w(WIDTH);
  localparam int PW = 2 * WIDTH;

  state_t          state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   out_q, out_d;
  logic            ovf_q, ovf_d;

  logic [PW-1:0]    step_acc;
  logic [PW-1:0]    step_mcand;
  logic [WIDTH-1:0] step_mplier;
  logic             step_zero;
  logic             last_iter;

  mul_step #(.WIDTH(WIDTH)) u_step (
    .acc_i         (acc_q),
    .mcand_i       (mcand_q),
    .mplier_i      (mplier_q),
    .acc_o         (step_acc),
    .mcand_o       (step_mcand),
    .mplier_o      (step_mplier),
    .mplier_zero_o (step_zero)
  );

`ifdef SEQ_MULTIPLIER_EARLY_DONE_EN
  assign last_iter = (cnt_q == CW'(1)) || step_zero;
`else
  logic unused_step_zero;
  assign unused_step_zero = step_zero;
  assign last_iter        = (cnt_q == CW'(1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, in1};
          mplier_d = in2;
          cnt_d    = CW'(WIDTH);
        end
      end
      S_RUN: begin
        acc_d    = step_acc;
        mcand_d  = step_mcand;
        mplier_d = step_mplier;
        cnt_d    = cnt_q - CW'(1);
        // Result registers are loaded from the final iteration on the same edge.
        if (last_iter) begin
          state_d = S_DONE;
          out_d   = step_acc;
          ovf_d   = |step_acc[PW-1:WIDTH];
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ready    = (state_q == S_IDLE);
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign out      = out_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - self-checking bench for seq_multiplier at WIDTH=4 and WIDTH=8
module tb_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst     = 1'b1;
  logic       start_r = 1'b0;
  logic       sel8    = 1'b0;
  logic [7:0] a_r     = '0;
  logic [7:0] b_r     = '0;

  logic        ready4, busy4, done4, ovf4;
  logic [7:0]  out4;
  logic        ready8, busy8, done8, ovf8;
  logic [15:0] out8;

  seq_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start_r & ~sel8), .in1(a_r[3:0]), .in2(b_r[3:0]),
    .ready(ready4), .busy(busy4), .done(done4), .out(out4), .overflow(ovf4)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start_r & sel8), .in1(a_r), .in2(b_r),
    .ready(ready8), .busy(busy8), .done(done8), .out(out8), .overflow(ovf8)
  );

  logic        c_ready, c_busy, c_done, c_ovf;
  logic [15:0] c_out;
  assign c_ready = sel8 ? ready8 : ready4;
  assign c_busy  = sel8 ? busy8  : busy4;
  assign c_done  = sel8 ? done8  : done4;
  assign c_ovf   = sel8 ? ovf8   : ovf4;
  assign c_out   = sel8 ? out8   : {8'h00, out4};

  int checks   = 0;
  int failures = 0;
  logic [15:0] last_out4 = '0;
  logic [15:0] last_out8 = '0;

  // Cycles from accept edge to the edge that enters DONE.
  function automatic int exp_lat(input int w, input logic [7:0] b);
    int n;
`ifdef SEQ_MULTIPLIER_EARLY_DONE_EN
    n = 1;
    for (int i = 0; i < w; i++) if (b[i]) n = i + 1;
`else
    n = w;
`endif
    return n;
  endfunction

  task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b,
                        input bit hold_start, input bit chained, input string name);
    logic [7:0]  am, bm;
    logic [15:0] p, prev;
    logic        povf;
    int lat, explat;
    bit seen, run_ok;
    am     = (w == 4) ? {4'h0, a[3:0]} : a;
    bm     = (w == 4) ? {4'h0, b[3:0]} : b;
    p      = {8'h00, am} * {8'h00, bm};
    povf   = ((p >> w) != 16'h0);
    explat = exp_lat(w, bm);
    prev   = (w == 4) ? last_out4 : last_out8;
    sel8   = (w == 8);
    if (!chained) @(negedge clk);
    checks++;
    if (c_ready !== 1'b1) begin
      failures++; $display("FAIL %s ready_before got=%b want=1", name, c_ready);
    end
    start_r = 1'b1; a_r = a; b_r = b;
    @(posedge clk); #1;
    if (!hold_start) start_r = 1'b0;
    lat = 0; seen = 0; run_ok = 1;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      a_r = 8'($urandom); b_r = 8'($urandom);
      if (lat == 1) begin
        checks++;
        if (c_out !== prev) begin
          failures++; $display("FAIL %s out_held got=%h want=%h", name, c_out, prev);
        end
      end
      if (c_done === 1'b1) seen = 1;
      else if (c_busy !== 1'b1 || c_ready !== 1'b0) run_ok = 0;
    end
    checks++;
    if (!run_ok) begin
      failures++; $display("FAIL %s run_flags got=bad want=busy1_ready0", name);
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL %s done_timeout got=none want=done", name);
    end
    checks++;
    if (lat - 1 !== explat) begin
      failures++; $display("FAIL %s latency got=%0d want=%0d", name, lat - 1, explat);
    end
    checks++;
    if (c_out !== p) begin
      failures++; $display("FAIL %s out got=%h want=%h", name, c_out, p);
    end
    checks++;
    if (c_ovf !== povf) begin
      failures++; $display("FAIL %s overflow got=%b want=%b", name, c_ovf, povf);
    end
    checks++;
    if (c_ready !== 1'b0 || c_busy !== 1'b0) begin
      failures++; $display("FAIL %s done_flags got=%b%b want=00", name, c_ready, c_busy);
    end
    if (w == 4) last_out4 = p; else last_out8 = p;
    @(negedge clk);
    checks++;
    if (c_done !== 1'b0 || c_ready !== 1'b1) begin
      failures++; $display("FAIL %s after_done got=done%b ready%b want=done0 ready1", name, c_done, c_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start_r = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ready4, busy4, done4, ovf4, out4} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      failures++; $display("FAIL reset4 got=%b%b%b%b %h want=1000 00", ready4, busy4, done4, ovf4, out4);
    end
    checks++;
    if ({ready8, busy8, done8, ovf8, out8} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      failures++; $display("FAIL reset8 got=%b%b%b%b %h want=1000 0000", ready8, busy8, done8, ovf8, out8);
    end
    rst = 1'b0; start_r = 1'b0;
  endtask

  task automatic test_directed;
    run_op(4, 8'd3,  8'd5,  0, 0, "3x5");
    run_op(4, 8'd15, 8'd15, 0, 0, "15x15");
    run_op(4, 8'd0,  8'd9,  0, 0, "0x9");
  endtask

  task automatic test_back_to_back;
    run_op(4, 8'd6, 8'd7, 1, 0, "b2b_6x7");
    run_op(4, 8'd2, 8'd5, 0, 1, "b2b_2x5");
  endtask

  task automatic test_hold;
    repeat (5) @(negedge clk);
    checks++;
    if (c_out !== last_out4) begin
      failures++; $display("FAIL idle_hold got=%h want=%h", c_out, last_out4);
    end
  endtask

  task automatic test_reset_mid;
    bit no_done;
    sel8 = 1'b0;
    @(negedge clk);
    start_r = 1'b1; a_r = 8'd9; b_r = 8'd9;
    @(posedge clk); #1;
    start_r = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; start_r = 1'b1;
    @(negedge clk);
    checks++;
    if ({ready4, busy4, done4, ovf4, out4} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      failures++; $display("FAIL mid_reset got=%b%b%b%b %h want=1000 00", ready4, busy4, done4, ovf4, out4);
    end
    rst = 1'b0; start_r = 1'b0;
    last_out4 = '0; last_out8 = '0;
    no_done = 1;
    repeat (8) begin
      @(negedge clk);
      if (done4 !== 1'b0 || ready4 !== 1'b1) no_done = 0;
    end
    checks++;
    if (!no_done) begin
      failures++; $display("FAIL mid_reset_quiet got=activity want=idle");
    end
    run_op(4, 8'd2, 8'd3, 0, 0, "post_reset_2x3");
  endtask

  task automatic test_wide;
    run_op(8, 8'd255, 8'd255, 0, 0, "w8_255x255");
    run_op(8, 8'd200, 8'd1,   0, 0, "w8_200x1");
    run_op(8, 8'd3,   8'd6,   0, 0, "w8_3x6");
    run_op(8, 8'd0,   8'd0,   0, 0, "w8_0x0");
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++)
      run_op(4, 8'($urandom), 8'($urandom), 0, 0, $sformatf("rand4_%0d", i));
    for (int i = 0; i < 8; i++)
      run_op(8, 8'($urandom), 8'($urandom), 0, 0, $sformatf("rand8_%0d", i));
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_wide();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Sequential shift-and-add unsigned multiplier. It is the inverse-direction companion to the team's combinational Divider: it computes a full-width product over WIDTH clock cycles instead of a single deep combinational path. It sits beside the Divider in the arithmetic datapath. The ALU controller drives it through a start/done handshake.

Parameters:
- WIDTH, default 4, operand bit width; must be >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin; accepted only when ready=1.
- in1  input  WIDTH  multiplicand; sampled on the accept edge only.
- in2  input  WIDTH  multiplier; sampled on the accept edge only.
- ready  output  1  high in IDLE only.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; out/overflow are valid during it.
- out  output  2*WIDTH  product register.
- overflow  output  1  high when out[2*WIDTH-1:WIDTH] != 0.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE, ready = 1, busy = 0, done = 0, out = 0, overflow = 0.
  - Internal accumulator, shifted multiplicand, multiplier and counter are all cleared.
- States: IDLE, RUN, DONE. Encoding is binary (2 bits).
- IDLE:
  - start=1 at an edge: capture in1 zero-extended to 2*WIDTH into mcand, in2 into mplier, clear acc, set cnt=WIDTH, and go to RUN.
  - start=0: stay in IDLE.
- RUN (one iteration per edge):
  - If mplier[0]=1, acc <= acc + mcand (2*WIDTH-bit add, no carry-out possible).
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt - 1.
  - When cnt=1 at the edge, move to DONE and load out/overflow from the final accumulated value in that same edge.
- DONE: done=1 for exactly one cycle, then unconditional return to IDLE.
- Latency: accept edge at k, so done=1 during the cycle after edge k+WIDTH. The next start can be accepted at edge k+WIDTH+2 at the earliest.
- out/overflow hold their value from DONE until the next DONE or a reset. They are not cleared on a new start.
- start while busy or in DONE: ignored, with no effect on the operation in flight. in1/in2 changes after the accept edge have no effect.
- Reset mid-operation: rst at any edge overrides everything, including a simultaneous start. The next state is IDLE with the reset values above, and no done pulse.
- Zero operands: a normal WIDTH-cycle run producing out=0.
- cnt width: $clog2(WIDTH+1) bits.

Optional Feature:
- Macro: SEQ_MULTIPLIER_EARLY_DONE_EN.
- Defined:
  - In RUN, if the shifted multiplier value being written (mplier>>1) is zero, go to DONE on that edge, regardless of cnt.
  - With in2=0 or in2=1, done appears the cycle after edge k+1.
  - The product is identical to the non-early case.
- Undefined: fixed WIDTH-cycle latency as specified above.

Decomposition:
- Shared package (seq_multiplier_pkg): state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2, and a CNT_W function/constant ($clog2(WIDTH+1)).
- Sub-module mul_step: purely combinational, holding one shift-add iteration.
  - Inputs: acc, mcand, mplier.
  - Outputs: next acc, next mcand, next mplier, and a zero-flag of the next mplier for the early-done option.
- The top level keeps the FSM, counter and output registers.

Test Plan:
- WIDTH=4, in1=3, in2=5, start pulse → done 4 cycles after accept; out=15, overflow=0; ready low during RUN/DONE.
- WIDTH=4, in1=15, in2=15 → out=8'hE1 (225), overflow=1. Then in1=0, in2=9 → out=0, overflow=0, still 4-cycle latency (macro undefined).
- Start asserted continuously, operands changed every cycle during RUN → only the accepted pair (6×7=42) appears. The second operation is accepted exactly 2 cycles after done.
- rst asserted at RUN cycle 2 of 9×9, together with start → next cycle state IDLE, out=0, no done pulse. A following 2×3 yields 6.
- WIDTH=8, in1=255, in2=255 → out=16'hFE01, overflow=1, done 8 cycles after accept.
- With SEQ_MULTIPLIER_EARLY_DONE_EN, WIDTH=8:
  - 200×1 → out=200, done 1 cycle after accept.
  - 3×6 → out=18, done 3 cycles after accept.
